// File: rtl/column_scan_pkg.sv
// Shared types and helpers for the column-scan driver.
package column_scan_pkg;

    typedef enum logic [2:0] {
        S_STARTUP,
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH
    } scan_state_t;

    localparam logic TOKEN_FIRST = 1'b0;
    localparam logic TOKEN_NEXT  = 1'b1;

    function automatic int col_idx_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

endpackage

// File: rtl/column_scan_driver_tx.sv
// Serialiser for the external shift-register chain: ser_data changes while
// ser_clk is low, each bit spans 2*CLK_DIV cycles, ser_clk idles low.
module scan_shift_tx #(
    parameter int SHIFT_W   = 8,
    parameter int CLK_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] data,
    output logic               busy,
    output logic               done,
    output logic               ser_clk,
    output logic               ser_data
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SHIFT_W + 1);

    logic [SHIFT_W-1:0] sreg;
    logic [DW-1:0]      div_cnt;
    logic [BW-1:0]      bits_left;
    logic               half_end;

    assign half_end = (div_cnt == DW'(CLK_DIV - 1));
    // Combinational so the owner can leave SHIFT on the same edge ser_clk falls.
    assign done = busy && ser_clk && half_end && (bits_left == BW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            sreg      <= '0;
            div_cnt   <= '0;
            bits_left <= '0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy      <= 1'b1;
                div_cnt   <= '0;
                bits_left <= BW'(SHIFT_W);
                ser_clk   <= 1'b0;
                ser_data  <= (MSB_FIRST != 0) ? data[SHIFT_W-1] : data[0];
                sreg      <= (MSB_FIRST != 0) ? (data << 1) : (data >> 1);
            end
        end else if (half_end) begin
            div_cnt <= '0;
            if (!ser_clk) begin
                ser_clk <= 1'b1;
            end else begin
                ser_clk   <= 1'b0;
                bits_left <= bits_left - 1'b1;
                if (bits_left == BW'(1)) begin
                    busy <= 1'b0;
                end else begin
                    ser_data <= (MSB_FIRST != 0) ? sreg[SHIFT_W-1] : sreg[0];
                    sreg     <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                end
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/column_scan_driver.sv
// Column-select driver: builds a token word per select pulse, shifts it into
// the external chain, blanks the outputs and pulses STCP to latch it.
module column_scan_driver
    import column_scan_pkg::*;
#(
    parameter int NUM_COLS     = 8,
    parameter int SHIFT_W      = 8,
    parameter int EXTRA_BITS   = 1,
    parameter int CLK_DIV      = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int ENABLE_AFTER = 2,
    parameter int MSB_FIRST    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             select_first,
    input  logic                             select_next,
    input  logic [EXTRA_BITS-1:0]            extra_bits,
    output logic                             ready,
    output logic [col_idx_w(NUM_COLS)-1:0]   column_idx,
    output logic                             overrun,
    output logic                             wrap_err,
    output logic                             ser_clk,
    output logic                             ser_data,
    output logic                             ser_stcp,
    output logic                             ser_n_enable
);

    localparam int CW = col_idx_w(NUM_COLS);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int EW = (ENABLE_AFTER > 0) ? $clog2(ENABLE_AFTER + 1) : 1;

    scan_state_t        state, state_next;
    logic [SHIFT_W-1:0] word, new_word;
    logic [BW-1:0]      blank_cnt;
    logic [EW-1:0]      en_cnt;
    logic               tx_start, tx_busy, tx_done;
    logic               enabled, pend_en, tok_q, startup_q;
    logic               sel, last_col, en_at_target;

    assign sel          = select_first | select_next;
    assign last_col     = (column_idx == CW'(NUM_COLS - 1));
    assign en_at_target = (int'(en_cnt) == ENABLE_AFTER);
    assign ready        = (state == S_IDLE) && !tx_busy;
    assign ser_stcp     = (state == S_LATCH);

    always_comb begin
        new_word                 = '1;
        new_word[0]              = select_first ? TOKEN_FIRST : TOKEN_NEXT;
        new_word[EXTRA_BITS:1]   = extra_bits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_STARTUP;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_STARTUP: state_next = S_SHIFT;
            S_IDLE:    if (sel) state_next = S_SHIFT;
            S_SHIFT:   if (tx_done) state_next = (BLANK_CYCLES > 0) ? S_BLANK : S_LATCH;
            S_BLANK:   if (int'(blank_cnt) >= BLANK_CYCLES - 1) state_next = S_LATCH;
            S_LATCH:   state_next = S_IDLE;
            default:   state_next = S_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word         <= '1;
            tx_start     <= 1'b0;
            blank_cnt    <= '0;
            en_cnt       <= '0;
            enabled      <= 1'b0;
            pend_en      <= 1'b0;
            tok_q        <= TOKEN_NEXT;
            startup_q    <= 1'b0;
            column_idx   <= '0;
            overrun      <= 1'b0;
            wrap_err     <= 1'b0;
            ser_n_enable <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            if (sel && !ready) overrun <= 1'b1;
            // The enable decision uses the count before this select bumps it.
            case (state)
                S_STARTUP: begin
                    word      <= '1;
                    tok_q     <= TOKEN_NEXT;
                    startup_q <= 1'b1;
                    pend_en   <= en_at_target;
                    tx_start  <= 1'b1;
                end
                S_IDLE: if (sel) begin
                    word      <= new_word;
                    tok_q     <= select_first ? TOKEN_FIRST : TOKEN_NEXT;
                    startup_q <= 1'b0;
                    pend_en   <= en_at_target;
                    tx_start  <= 1'b1;
                    if (select_first && !en_at_target) en_cnt <= en_cnt + 1'b1;
                    if (!select_first && last_col) wrap_err <= 1'b1;
                end
                S_BLANK: blank_cnt <= blank_cnt + 1'b1;
                S_LATCH: begin
                    if (pend_en) enabled <= 1'b1;
                    ser_n_enable <= !(enabled || pend_en);
                end
                default: ;
            endcase
            if (state_next == S_BLANK && state != S_BLANK) begin
                ser_n_enable <= 1'b1;
                blank_cnt    <= '0;
            end
            if (state_next == S_LATCH && state != S_LATCH && !startup_q)
                column_idx <= (tok_q == TOKEN_FIRST || last_col) ? '0 : column_idx + 1'b1;
        end
    end

    scan_shift_tx #(
        .SHIFT_W  (SHIFT_W),
        .CLK_DIV  (CLK_DIV),
        .MSB_FIRST(MSB_FIRST)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .data    (word),
        .busy    (tx_busy),
        .done    (tx_done),
        .ser_clk (ser_clk),
        .ser_data(ser_data)
    );

endmodule

// File: tb/tb_column_scan_driver.sv
// Directed bench: default-configured instance plus a wide/slow instance.
module tb_column_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_first = 1'b0, a_next = 1'b0;
    logic [0:0] a_extra = '0;
    logic       a_ready, a_ovr, a_wrap, a_sclk, a_sdat, a_stcp, a_nen;
    logic [2:0] a_idx;

    logic       b_first = 1'b0, b_next = 1'b0;
    logic [3:0] b_extra = '0;
    logic       b_ready, b_ovr, b_wrap, b_sclk, b_sdat, b_stcp, b_nen;
    logic [2:0] b_idx;

    column_scan_driver dut_a (
        .clk(clk), .rst(rst), .select_first(a_first), .select_next(a_next),
        .extra_bits(a_extra), .ready(a_ready), .column_idx(a_idx),
        .overrun(a_ovr), .wrap_err(a_wrap), .ser_clk(a_sclk), .ser_data(a_sdat),
        .ser_stcp(a_stcp), .ser_n_enable(a_nen)
    );

    column_scan_driver #(
        .NUM_COLS(8), .SHIFT_W(16), .EXTRA_BITS(4), .CLK_DIV(3),
        .BLANK_CYCLES(0), .ENABLE_AFTER(2), .MSB_FIRST(1)
    ) dut_b (
        .clk(clk), .rst(rst), .select_first(b_first), .select_next(b_next),
        .extra_bits(b_extra), .ready(b_ready), .column_idx(b_idx),
        .overrun(b_ovr), .wrap_err(b_wrap), .ser_clk(b_sclk), .ser_data(b_sdat),
        .ser_stcp(b_stcp), .ser_n_enable(b_nen)
    );

    int passed = 0, total = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Negedge monitors
    int a_rises = 0, a_stcp_cnt = 0, a_stcp_cyc = -1, a_ready_cyc = -1, a_run = 0, a_blank_run = 0;
    logic [31:0] a_word = '0;
    logic a_prev = 1'b0;
    always @(negedge clk) begin
        if (a_sclk && !a_prev) begin a_word = {a_word[30:0], a_sdat}; a_rises++; end
        a_prev = a_sclk;
        if (a_stcp) begin a_stcp_cnt++; a_stcp_cyc = cyc; a_blank_run = a_run; end
        if (a_ready && a_ready_cyc < 0) a_ready_cyc = cyc;
        a_run = a_nen ? a_run + 1 : 0;
    end

    int b_rises = 0, b_stcp_cnt = 0, b_stcp_cyc = -1, b_ready_cyc = -1, b_rise1 = -1, b_rise2 = -1;
    logic [31:0] b_word = '0;
    logic b_prev = 1'b0;
    always @(negedge clk) begin
        if (b_sclk && !b_prev) begin
            b_word = {b_word[30:0], b_sdat};
            b_rises++;
            if (b_rises == 1) b_rise1 = cyc;
            if (b_rises == 2) b_rise2 = cyc;
        end
        b_prev = b_sclk;
        if (b_stcp) begin b_stcp_cnt++; b_stcp_cyc = cyc; end
        if (b_ready && b_ready_cyc < 0) b_ready_cyc = cyc;
    end

    task automatic clr_a();
        a_rises = 0; a_stcp_cnt = 0; a_stcp_cyc = -1; a_ready_cyc = -1; a_word = '0;
    endtask

    task automatic clr_b();
        b_rises = 0; b_stcp_cnt = 0; b_stcp_cyc = -1; b_ready_cyc = -1; b_word = '0;
        b_rise1 = -1; b_rise2 = -1;
    endtask

    task automatic wait_a_ready(input string name);
        for (int i = 0; i < 200 && a_ready_cyc < 0; i++) @(negedge clk);
        check({name, "_ready_seen"}, int'(a_ready_cyc >= 0), 1);
    endtask

    task automatic wait_b_ready(input string name);
        for (int i = 0; i < 400 && b_ready_cyc < 0; i++) @(negedge clk);
        check({name, "_ready_seen"}, int'(b_ready_cyc >= 0), 1);
    endtask

    task automatic pulse_a(input logic f, input logic n, input logic ex, output int t);
        @(posedge clk); #1;
        a_first = f; a_next = n; a_extra = ex;
        @(posedge clk); #1;
        t = cyc;
        a_first = 1'b0; a_next = 1'b0;
        clr_a();
    endtask

    task automatic pulse_b(input logic f, input logic n, input logic [3:0] ex, output int t);
        @(posedge clk); #1;
        b_first = f; b_next = n; b_extra = ex;
        @(posedge clk); #1;
        t = cyc;
        b_first = 1'b0; b_next = 1'b0;
        clr_b();
    endtask

    task automatic check_a_reset(input string name);
        check({name, "_ready"}, int'(a_ready), 0);
        check({name, "_idx"}, int'(a_idx), 0);
        check({name, "_overrun"}, int'(a_ovr), 0);
        check({name, "_wrap"}, int'(a_wrap), 0);
        check({name, "_sclk"}, int'(a_sclk), 0);
        check({name, "_sdata"}, int'(a_sdat), 0);
        check({name, "_stcp"}, int'(a_stcp), 0);
        check({name, "_nen"}, int'(a_nen), 1);
    endtask

    task automatic check_a_startup(input string name, input int e0);
        wait_a_ready(name);
        check({name, "_rises"}, a_rises, 8);
        check({name, "_word"}, int'(a_word[7:0]), 8'hFF);
        check({name, "_stcp_lat"}, a_stcp_cyc - e0, 19);
        check({name, "_ready_lat"}, a_ready_cyc - e0, 20);
        check({name, "_nen"}, int'(a_nen), 1);
        check({name, "_idx"}, int'(a_idx), 0);
    endtask

    typedef struct {
        logic f;
        logic n;
        logic ex;
        int   word;
        int   idx;
        int   nen;
        int   wrap;
        int   blank;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int t, t0;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'hFE, 0, 1, 0, -1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'hFC, 0, 1, 0, -1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'hFE, 0, 0, 0, -1};
        for (int i = 3; i < 10; i++) begin
            logic ex;
            ex = logic'(i % 2);
            vecs[i] = '{1'b0, 1'b1, ex, ex ? 8'hFF : 8'hFD, i - 2, 0, 0, 2};
        end
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'hFD, 0, 0, 1, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_a_reset("rst");
        check("rst_b_nen", int'(b_nen), 1);
        check("rst_b_ready", int'(b_ready), 0);

        // Startup word after reset release
        clr_a(); clr_b();
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc;
        check_a_startup("startup", t0 + 1);

        wait_b_ready("b_startup");
        check("b_startup_rises", b_rises, 16);
        check("b_startup_word", int'(b_word[15:0]), 16'hFFFF);
        check("b_startup_stcp_lat", b_stcp_cyc - (t0 + 1), 97);

        // Table-driven select sequence on the default instance
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            pulse_a(vecs[i].f, vecs[i].n, vecs[i].ex, t);
            wait_a_ready(nm);
            check({nm, "_rises"}, a_rises, 8);
            check({nm, "_word"}, int'(a_word[7:0]), vecs[i].word);
            check({nm, "_stcp_lat"}, a_stcp_cyc - t, 19);
            check({nm, "_ready_lat"}, a_ready_cyc - t, 20);
            check({nm, "_stcp_cnt"}, a_stcp_cnt, 1);
            check({nm, "_idx"}, int'(a_idx), vecs[i].idx);
            check({nm, "_nen"}, int'(a_nen), vecs[i].nen);
            check({nm, "_wrap"}, int'(a_wrap), vecs[i].wrap);
            if (vecs[i].blank >= 0) check({nm, "_blank_run"}, a_blank_run, vecs[i].blank);
        end
        check("pre_overrun", int'(a_ovr), 0);

        // Simultaneous selects, then a select while busy
        pulse_a(1'b1, 1'b1, 1'b1, t);
        repeat (4) @(posedge clk);
        #1;
        a_next = 1'b1;
        @(posedge clk); #1;
        a_next = 1'b0;
        wait_a_ready("both");
        check("both_word", int'(a_word[7:0]), 8'hFE);
        check("both_idx", int'(a_idx), 0);
        check("busy_overrun", int'(a_ovr), 1);
        repeat (40) @(negedge clk);
        check("busy_no_extra_txn", a_stcp_cnt, 1);
        check("busy_idx_held", int'(a_idx), 0);

        // Wide/slow instance
        pulse_b(1'b0, 1'b1, 4'b1010, t);
        wait_b_ready("b_next");
        check("b_next_rises", b_rises, 16);
        check("b_next_word", int'(b_word[15:0]), 16'hFFF5);
        check("b_next_stcp_lat", b_stcp_cyc - t, 97);
        check("b_next_ready_lat", b_ready_cyc - t, 98);
        check("b_sclk_period", b_rise2 - b_rise1, 6);
        check("b_next_idx", int'(b_idx), 1);
        check("b_next_wrap", int'(b_wrap), 0);
        pulse_b(1'b1, 1'b0, 4'b0000, t);
        wait_b_ready("b_first");
        check("b_first_word", int'(b_word[15:0]), 16'hFFE0);
        check("b_first_stcp_lat", b_stcp_cyc - t, 97);
        check("b_first_idx", int'(b_idx), 0);

        // Reset asserted during the 4th bit of a shift
        pulse_a(1'b1, 1'b0, 1'b1, t);
        repeat (7) @(posedge clk);
        #3;
        check("midshift_rises_before_rst", a_rises, 3);
        rst = 1'b1;
        #1;
        check_a_reset("midrst");
        repeat (2) @(posedge clk);
        clr_a();
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc;
        check_a_startup("restart", t0 + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
